uop_scheduler: RTL and testbench
================================

# uop_scheduler

Issue scheduler sitting directly downstream of the reservation stations. Tracks allocation age of NUM_ST stations, selects each cycle the oldest ready station whose micro-op has no register or memory-ordering hazard against any older in-flight station, and returns `sched_ack` to that station. The selected micro-op is captured in a one-entry issue register that feeds the register-file/ALU/LSU execute stage through a valid/ready handshake.

## Interface
- NUM_ST, 4, number of stations (2..8); IDX_W = clog2(NUM_ST)
- UOP_W, 69, packed uop width: {pc16, k16, agu_k16, a3, b3, d4, fn4, mask_carry, save_flags, fwd_rmw, st_mem, ld_mem, mem_width, bypass_b}, MSB first
- LOCK_W, 14, packed lock width: {lock_loads, lock_wr4, lock_rd0_3, lock_rd1_3, lock_rd2_3}
- clk  in  1  clock
- a_rst  in  1  reset, asynchronous, active-high
- st_alloc  in  NUM_ST  one-hot pulse: station i accepted a new instruction (id_feed & id_ack); at most one bit per cycle
- st_ready  in  NUM_ST  station i presents a schedulable step
- st_will_complete  in  NUM_ST  station i's current step is its last
- st_uop  in  NUM_ST*UOP_W  flattened per-station uop, station 0 in LSBs
- st_lock  in  NUM_ST*LOCK_W  flattened per-station locks
- sched_ack  out  NUM_ST  one-hot grant, combinational
- ex_valid  out  1  issue register holds a uop
- ex_uop  out  UOP_W  issued uop
- ex_station  out  IDX_W  station index of issued uop
- ex_ready  in  1  execute stage accepts ex_uop this cycle
- stall_hazard  out  1  some station ready but all blocked by hazards (status)

## Operation
- Per-station `busy[i]`: set on st_alloc[i]; cleared on sched_ack[i] & st_will_complete[i]. If both in same cycle, set wins.
- Age matrix `older[i][j]` (i older than j): on st_alloc[k], row k cleared, column k set to busy[j] for every j != k (existing busy stations become older than k). Diagonal always 0.
- Hazard of candidate i against j, evaluated only when busy[j] & older[j][i]:
  - RAW: i's a or b address equals j.lock_wr[2:0] with j.lock_wr[3]=1.
  - WAW: i.d[3]=1 and i.d[2:0] equals j.lock_wr[2:0] with j.lock_wr[3]=1.
  - WAR: i.d[3]=1 and i.d[2:0] equals j.lock_rd0, lock_rd1 or lock_rd2.
  - MEM: i.ld_mem=1 and j.lock_loads=1.
  - a/b compared only on 3-bit address; a station never hazards against itself.
- Eligible(i) = busy[i] & st_ready[i] & no hazard. Winner = eligible station with no eligible older station; unique by construction.
- Issue register can accept when !ex_valid | ex_ready. sched_ack[winner]=1 only when it can accept; otherwise all zero.
- On grant: ex_uop <= winner uop, ex_station <= winner, ex_valid <= 1. On ex_ready without grant: ex_valid <= 0.
- stall_hazard = |(busy & st_ready) & no eligible station.

## Timing
- Reset: busy=0, older=0, ex_valid=0, ex_uop=0, ex_station=0, sched_ack=0, stall_hazard=0, perf counters=0.
- st_ready→sched_ack: zero cycles (combinational); sched_ack→ex_valid: 1 cycle.
- Full throughput: one grant per cycle while ex_ready held 1.
- ex_ready=0 with ex_valid=1: ex_uop stable, no grant, stations hold state.
- A station allocated in cycle t is ineligible until t+1 (busy registered).
- Reset asserted mid-operation clears all state immediately; the in-flight ex_uop is dropped.

## Configuration
- UOP_SCHED_PERF_EN defined: adds outputs `perf_issued` (16 bit, +1 per grant) and `perf_stalled` (16 bit, +1 per cycle stall_hazard=1); both wrap 0xFFFF→0x0000, reset to 0.
- Not defined: ports and counters absent; no other behaviour change.

## Test plan
- Single station: alloc st0, st_ready[0]=1, ex_ready=1 → sched_ack=0001 next cycle; ex_valid=1 and ex_station=0 one cycle later.
- Age: alloc st2 then st1, both ready, no hazards → st2 granted first, st1 in the following cycle.
- RAW: st0 older with lock_wr=4'b1011, st1 ready with a=3'b011 → st1 blocked, stall_hazard=1 until st0 completes; then st1 granted.
- MEM: st0 older with lock_loads=1, st1 ready with ld_mem=1, st2 ready ALU-only → st2 granted, st1 blocked.
- Backpressure: ex_ready=0 with ex_valid=1 and st3 ready → sched_ack=0000, ex_uop unchanged; ex_ready=1 → st3 granted same cycle.
- Simultaneous completion and alloc of st1 → busy[1] stays 1, st1 becomes youngest.

Source files
------------

// File: rtl/uop_scheduler.sv
// Oldest-ready issue scheduler with register/memory hazard screening and a one-entry issue register.
// Define UOP_SCHED_PERF_EN to add the perf_issued / perf_stalled counters.

// Hazard of one candidate micro-op against the locks held by one older station.
module uop_sched_haz (
   input  logic [2:0]  i_a,
   input  logic [2:0]  i_b,
   input  logic [3:0]  i_d,
   input  logic        i_ld,
   input  logic [13:0] i_lock,
   output logic        o_haz
);
   logic       w_loads;
   logic [3:0] w_wr;
   logic [2:0] w_rd0, w_rd1, w_rd2;
   logic       w_raw, w_waw, w_war, w_mem;

   assign {w_loads, w_wr, w_rd0, w_rd1, w_rd2} = i_lock;

   assign w_raw = w_wr[3] & ((i_a == w_wr[2:0]) | (i_b == w_wr[2:0]));
   assign w_waw = w_wr[3] & i_d[3] & (i_d[2:0] == w_wr[2:0]);
   assign w_war = i_d[3] & ((i_d[2:0] == w_rd0) | (i_d[2:0] == w_rd1) | (i_d[2:0] == w_rd2));
   assign w_mem = i_ld & w_loads;
   assign o_haz = w_raw | w_waw | w_war | w_mem;
endmodule

module uop_scheduler #(
   parameter  int NUM_ST = 4,
   parameter  int UOP_W  = 69,
   parameter  int LOCK_W = 14,
   localparam int IDX_W  = (NUM_ST > 1) ? $clog2(NUM_ST) : 1
) (
   input  logic                      clk,
   input  logic                      a_rst,
   input  logic [NUM_ST-1:0]         st_alloc,
   input  logic [NUM_ST-1:0]         st_ready,
   input  logic [NUM_ST-1:0]         st_will_complete,
   input  logic [NUM_ST*UOP_W-1:0]   st_uop,
   input  logic [NUM_ST*LOCK_W-1:0]  st_lock,
   output logic [NUM_ST-1:0]         sched_ack,
   output logic                      ex_valid,
   output logic [UOP_W-1:0]          ex_uop,
   output logic [IDX_W-1:0]          ex_station,
   input  logic                      ex_ready,
`ifdef UOP_SCHED_PERF_EN
   output logic [15:0]               perf_issued,
   output logic [15:0]               perf_stalled,
`endif
   output logic                      stall_hazard
);
   // Field positions inside the packed uop (LSB of each field)
   localparam int A_LSB  = 18;
   localparam int B_LSB  = 15;
   localparam int D_LSB  = 11;
   localparam int LD_BIT = 2;

   logic [NUM_ST-1:0][UOP_W-1:0]  w_uops;
   logic [NUM_ST-1:0][LOCK_W-1:0] w_locks;

   logic [NUM_ST-1:0]             r_busy;
   // r_older[i][j]: station i was allocated before station j
   logic [NUM_ST-1:0][NUM_ST-1:0] r_older;
   // w_blk[i][j]: busy older station j hazards candidate i
   logic [NUM_ST-1:0][NUM_ST-1:0] w_blk;
   logic [NUM_ST-1:0]             w_haz;
   logic [NUM_ST-1:0]             w_elig;
   logic [NUM_ST-1:0]             w_win;
   logic [IDX_W-1:0]              w_win_idx;
   logic [UOP_W-1:0]              w_win_uop;
   logic                          w_can_accept;
   logic                          w_grant;

   assign w_uops  = st_uop;
   assign w_locks = st_lock;

   genvar gi, gj;
   generate
      for (gi = 0; gi < NUM_ST; gi++) begin : g_st
         for (gj = 0; gj < NUM_ST; gj++) begin : g_vs
            if (gi == gj) begin : g_self
               assign w_blk[gi][gj] = 1'b0;
            end else begin : g_chk
               logic w_h;
               uop_sched_haz u_haz (
                  .i_a    (w_uops[gi][A_LSB +: 3]),
                  .i_b    (w_uops[gi][B_LSB +: 3]),
                  .i_d    (w_uops[gi][D_LSB +: 4]),
                  .i_ld   (w_uops[gi][LD_BIT]),
                  .i_lock (w_locks[gj]),
                  .o_haz  (w_h)
               );
               assign w_blk[gi][gj] = w_h & r_busy[gj] & r_older[gj][gi];
            end
         end
         assign w_haz[gi] = |w_blk[gi];
      end
   endgenerate

   assign w_elig = r_busy & st_ready & ~w_haz;

   // Busy stations are totally ordered by age, so at most one survives this filter
   always_comb begin
      w_win = '0;
      for (int i = 0; i < NUM_ST; i++) begin
         w_win[i] = w_elig[i];
         for (int j = 0; j < NUM_ST; j++)
            if (j != i && w_elig[j] && r_older[j][i]) w_win[i] = 1'b0;
      end
   end

   always_comb begin
      w_win_idx = '0;
      w_win_uop = '0;
      for (int i = 0; i < NUM_ST; i++) begin
         if (w_win[i]) begin
            w_win_idx = IDX_W'(i);
            w_win_uop = w_uops[i];
         end
      end
   end

   assign w_can_accept = ~ex_valid | ex_ready;
   assign sched_ack    = w_can_accept ? w_win : '0;
   assign w_grant      = |sched_ack;
   assign stall_hazard = (|(r_busy & st_ready)) & ~(|w_elig);

   // Allocation outranks completion when both hit the same station
   always_ff @(posedge clk or posedge a_rst) begin
      if (a_rst) begin
         r_busy  <= '0;
         r_older <= '0;
      end else begin
         for (int i = 0; i < NUM_ST; i++) begin
            if (st_alloc[i])
               r_busy[i] <= 1'b1;
            else if (sched_ack[i] && st_will_complete[i])
               r_busy[i] <= 1'b0;
         end
         for (int k = 0; k < NUM_ST; k++) begin
            if (st_alloc[k]) begin
               r_older[k] <= '0;
               for (int j = 0; j < NUM_ST; j++)
                  if (j != k) r_older[j][k] <= r_busy[j];
            end
         end
      end
   end

   always_ff @(posedge clk or posedge a_rst) begin
      if (a_rst) begin
         ex_valid   <= 1'b0;
         ex_uop     <= '0;
         ex_station <= '0;
      end else if (w_grant) begin
         ex_valid   <= 1'b1;
         ex_uop     <= w_win_uop;
         ex_station <= w_win_idx;
      end else if (ex_ready) begin
         ex_valid   <= 1'b0;
      end
   end

`ifdef UOP_SCHED_PERF_EN
   always_ff @(posedge clk or posedge a_rst) begin
      if (a_rst) begin
         perf_issued  <= '0;
         perf_stalled <= '0;
      end else begin
         if (w_grant)      perf_issued  <= perf_issued + 16'd1;
         if (stall_hazard) perf_stalled <= perf_stalled + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_uop_scheduler.sv
// Randomized + directed bench for uop_scheduler against an allocation-timestamp reference model.
module tb_uop_scheduler;
   localparam int N  = 4;
   localparam int UW = 69;
   localparam int LW = 14;

   logic            clk = 1'b0;
   logic            a_rst = 1'b1;
   logic [N-1:0]    st_alloc, st_ready, st_will_complete, sched_ack;
   logic [N*UW-1:0] st_uop;
   logic [N*LW-1:0] st_lock;
   logic            ex_valid, ex_ready, stall_hazard;
   logic [UW-1:0]   ex_uop;
   logic [1:0]      ex_station;
`ifdef UOP_SCHED_PERF_EN
   logic [15:0]     perf_issued, perf_stalled;
`endif

   always #5 clk = ~clk;

   uop_scheduler #(.NUM_ST(N), .UOP_W(UW), .LOCK_W(LW)) dut (
      .clk(clk), .a_rst(a_rst),
      .st_alloc(st_alloc), .st_ready(st_ready), .st_will_complete(st_will_complete),
      .st_uop(st_uop), .st_lock(st_lock),
      .sched_ack(sched_ack), .ex_valid(ex_valid), .ex_uop(ex_uop),
      .ex_station(ex_station), .ex_ready(ex_ready),
`ifdef UOP_SCHED_PERF_EN
      .perf_issued(perf_issued), .perf_stalled(perf_stalled),
`endif
      .stall_hazard(stall_hazard)
   );

   // Per-station stimulus fields
   logic [UW-1:0] f_raw [N];
   logic [2:0]    f_a [N], f_b [N], f_r0 [N], f_r1 [N], f_r2 [N];
   logic [3:0]    f_d [N], f_wr [N];
   logic          f_ld [N], f_ll [N];

   // Reference model: age is an allocation sequence number
   bit            m_busy [N];
   int unsigned   m_ts [N];
   int unsigned   m_seq;
   bit            m_exv;
   logic [UW-1:0] m_uop;
   int            m_st;
   logic [15:0]   m_iss, m_stl;

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [UW-1:0] uop_of(input int i);
      logic [UW-1:0] u;
      u = f_raw[i];
      u[20:18] = f_a[i];
      u[17:15] = f_b[i];
      u[14:11] = f_d[i];
      u[2]     = f_ld[i];
      return u;
   endfunction

   function automatic bit conflict(input int i, input int j);
      bit raw, waw, war, mem;
      raw = f_wr[j][3] && (f_a[i] == f_wr[j][2:0] || f_b[i] == f_wr[j][2:0]);
      waw = f_wr[j][3] && f_d[i][3] && (f_d[i][2:0] == f_wr[j][2:0]);
      war = f_d[i][3] && (f_d[i][2:0] == f_r0[j] || f_d[i][2:0] == f_r1[j] || f_d[i][2:0] == f_r2[j]);
      mem = f_ld[i] && f_ll[j];
      return raw || waw || war || mem;
   endfunction

   task automatic pack();
      for (int i = 0; i < N; i++) begin
         st_uop[i*UW +: UW]  = uop_of(i);
         st_lock[i*LW +: LW] = {f_ll[i], f_wr[i], f_r0[i], f_r1[i], f_r2[i]};
      end
   endtask

   task automatic predict(output logic [N-1:0] ack, output bit stall);
      bit elig [N];
      bit any_br;
      int win;
      any_br = 0;
      win = -1;
      for (int i = 0; i < N; i++) begin
         bit blocked;
         blocked = 0;
         for (int j = 0; j < N; j++)
            if (j != i && m_busy[j] && m_ts[j] < m_ts[i] && conflict(i, j)) blocked = 1;
         elig[i] = m_busy[i] && st_ready[i] && !blocked;
         if (m_busy[i] && st_ready[i]) any_br = 1;
      end
      for (int i = 0; i < N; i++)
         if (elig[i] && (win < 0 || m_ts[i] < m_ts[win])) win = i;
      ack = '0;
      if (win >= 0 && (!m_exv || ex_ready)) ack[win] = 1'b1;
      stall = any_br && (win < 0);
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin m_busy[i] = 0; m_ts[i] = 0; end
      m_seq = 1; m_exv = 0; m_uop = '0; m_st = 0; m_iss = '0; m_stl = '0;
   endtask

   task automatic clr();
      st_alloc = '0; st_ready = '0; st_will_complete = '0; ex_ready = 1'b1;
      for (int i = 0; i < N; i++) begin
         f_raw[i] = '0; f_a[i] = '0; f_b[i] = '0; f_d[i] = '0; f_ld[i] = 0;
         f_ll[i] = 0; f_wr[i] = '0; f_r0[i] = '0; f_r1[i] = '0; f_r2[i] = '0;
      end
      pack();
   endtask

   // Sample mid-cycle and compare every output to the model
   task automatic look();
      logic [N-1:0] e_ack;
      bit e_stall;
      pack();
      @(negedge clk);
      predict(e_ack, e_stall);
      chk("sched_ack", sched_ack, e_ack);
      chk("stall_hazard", stall_hazard, e_stall);
      chk("ex_valid", ex_valid, m_exv);
      chk("ex_uop", ex_uop, m_uop);
      chk("ex_station", ex_station, m_st);
`ifdef UOP_SCHED_PERF_EN
      chk("perf_issued", perf_issued, m_iss);
      chk("perf_stalled", perf_stalled, m_stl);
`endif
   endtask

   task automatic tick();
      logic [N-1:0] e_ack;
      bit e_stall;
      predict(e_ack, e_stall);
      @(posedge clk);
      for (int i = 0; i < N; i++) begin
         if (e_ack[i]) begin m_exv = 1; m_uop = uop_of(i); m_st = i; end
      end
      if (e_ack == '0 && ex_ready) m_exv = 0;
      if (e_ack != '0) m_iss = m_iss + 16'd1;
      if (e_stall)     m_stl = m_stl + 16'd1;
      for (int i = 0; i < N; i++) begin
         if (st_alloc[i]) begin m_busy[i] = 1; m_ts[i] = m_seq; m_seq++; end
         else if (e_ack[i] && st_will_complete[i]) m_busy[i] = 0;
      end
      #1;
   endtask

   task automatic do_reset();
      a_rst = 1'b1;
      clr();
      repeat (2) @(posedge clk);
      #1;
      model_reset();
      chk("rst_ack", sched_ack, 0);
      chk("rst_ex_valid", ex_valid, 0);
      chk("rst_ex_uop", ex_uop, 0);
      chk("rst_ex_station", ex_station, 0);
      chk("rst_stall", stall_hazard, 0);
      a_rst = 1'b0;
   endtask

   task automatic rnd_inputs();
      logic [95:0] t;
      st_alloc = '0;
      if ($urandom_range(0, 9) < 4) begin
         int k;
         k = $urandom_range(0, N-1);
         if (!m_busy[k]) st_alloc[k] = 1'b1;
      end
      st_ready         = N'($urandom);
      st_will_complete = N'($urandom);
      ex_ready         = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
         t = {$urandom, $urandom, $urandom};
         f_raw[i] = t[UW-1:0];
         f_a[i]   = 3'($urandom);
         f_b[i]   = 3'($urandom);
         f_d[i]   = 4'($urandom);
         f_ld[i]  = ($urandom_range(0, 2) == 0);
         f_ll[i]  = ($urandom_range(0, 4) == 0);
         f_wr[i]  = ($urandom_range(0, 1) == 0) ? 4'($urandom) : 4'h0;
         f_r0[i]  = 3'($urandom);
         f_r1[i]  = 3'($urandom);
         f_r2[i]  = 3'($urandom);
      end
   endtask

   initial begin
      logic [UW-1:0] held;
      logic [95:0]   t;

      // single station: grant the cycle after alloc, issue one cycle later
      do_reset();
      st_alloc = 4'b0001; st_ready = 4'b0001; st_will_complete = 4'b0001;
      look(); chk("single_alloc_cycle", sched_ack, 4'b0000); tick();
      st_alloc = '0;
      look(); chk("single_ack", sched_ack, 4'b0001); tick();
      st_ready = '0;
      look(); chk("single_ex_valid", ex_valid, 1); chk("single_ex_station", ex_station, 0); tick();

      // age: st2 then st1
      do_reset();
      st_alloc = 4'b0100; look(); tick();
      st_alloc = 4'b0010; look(); tick();
      st_alloc = '0; st_ready = 4'b0110; st_will_complete = 4'b0110;
      look(); chk("age_first", sched_ack, 4'b0100); tick();
      look(); chk("age_second", sched_ack, 4'b0010); tick();

      // RAW on r3
      do_reset();
      f_wr[0] = 4'b1011; f_a[1] = 3'b011;
      st_alloc = 4'b0001; look(); tick();
      st_alloc = 4'b0010; look(); tick();
      st_alloc = '0; st_ready = 4'b0010;
      look(); chk("raw_blocked", sched_ack, 4'b0000); chk("raw_stall", stall_hazard, 1); tick();
      look(); chk("raw_stall_hold", stall_hazard, 1); tick();
      st_ready = 4'b0011; st_will_complete = 4'b0001;
      look(); chk("raw_older_done", sched_ack, 4'b0001); tick();
      st_ready = 4'b0010;
      look(); chk("raw_released", sched_ack, 4'b0010); chk("raw_no_stall", stall_hazard, 0); tick();

      // memory ordering
      do_reset();
      f_ll[0] = 1; f_ld[1] = 1;
      st_alloc = 4'b0001; look(); tick();
      st_alloc = 4'b0010; look(); tick();
      st_alloc = 4'b0100; look(); tick();
      st_alloc = '0; st_ready = 4'b0110; st_will_complete = 4'b0110;
      look(); chk("mem_alu_wins", sched_ack, 4'b0100); tick();
      look(); chk("mem_ld_blocked", sched_ack, 4'b0000); chk("mem_stall", stall_hazard, 1); tick();

      // backpressure
      do_reset();
      f_raw[3] = {UW{1'b1}};
      st_alloc = 4'b1000; look(); tick();
      st_alloc = '0; st_ready = 4'b1000; ex_ready = 1'b0;
      look(); chk("bp_first_grant", sched_ack, 4'b1000); tick();
      held = uop_of(3);
      t = {$urandom, $urandom, $urandom}; f_raw[3] = t[UW-1:0]; f_a[3] = 3'd5;
      look(); chk("bp_no_grant", sched_ack, 4'b0000); chk("bp_hold", ex_uop, held); tick();
      ex_ready = 1'b1;
      look(); chk("bp_regrant", sched_ack, 4'b1000); tick();
      look(); chk("bp_new_uop", ex_uop, uop_of(3)); tick();

      // simultaneous completion and re-alloc of st1
      do_reset();
      st_alloc = 4'b0010; look(); tick();
      st_alloc = 4'b0100; look(); tick();
      st_alloc = 4'b0010; st_ready = 4'b0010; st_will_complete = 4'b0010;
      look(); chk("sim_ack", sched_ack, 4'b0010); tick();
      st_alloc = '0; st_ready = 4'b0110; st_will_complete = 4'b0000;
      look(); chk("sim_youngest", sched_ack, 4'b0100); tick();
      look(); chk("sim_still_busy", sched_ack, 4'b0100); tick();

      // randomized run with an asynchronous reset mid-stream
      do_reset();
      for (int c = 0; c < 1500; c++) begin
         rnd_inputs();
         look();
         tick();
         if (c == 700) begin
            #2 a_rst = 1'b1;
            #1;
            chk("midrst_ex_valid", ex_valid, 0);
            chk("midrst_ack", sched_ack, 0);
            chk("midrst_ex_uop", ex_uop, 0);
            model_reset();
            st_alloc = '0;
            @(posedge clk);
            #1 a_rst = 1'b0;
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
